// File: rtl/tc_program_mem_pkg.sv
// Shared types and default sizes for the program memory slice.
// The optional load checksum is enabled with `define TC_PROGRAM_MEM_CHECKSUM_EN.
package tc_program_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_DEPTH  = 256;
    localparam int DEF_LANES  = 4;

endpackage

// File: rtl/tc_program_mem_if.sv
// Read port and load-stream bundle for tc_program_mem.
// load_csum exists only when TC_PROGRAM_MEM_CHECKSUM_EN is defined.
interface tc_program_mem_if
    import tc_program_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int LANES  = DEF_LANES
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0]       addr;
    logic                    rd_en;
    logic [LANES*WORD_W-1:0] rd_data;
    logic                    rd_valid;
    logic                    load_start;
    logic                    load_valid;
    logic                    load_ready;
    logic [WORD_W-1:0]       load_data;
    logic                    load_last;
    logic                    load_done;
    logic [ADDR_W:0]         load_count;
`ifdef TC_PROGRAM_MEM_CHECKSUM_EN
    logic [WORD_W-1:0]       load_csum;
`endif

    modport master (
        output addr, rd_en, load_start, load_valid, load_data, load_last,
`ifdef TC_PROGRAM_MEM_CHECKSUM_EN
        input  load_csum,
`endif
        input  rd_data, rd_valid, load_ready, load_done, load_count
    );

    modport slave (
        input  addr, rd_en, load_start, load_valid, load_data, load_last,
`ifdef TC_PROGRAM_MEM_CHECKSUM_EN
        output load_csum,
`endif
        output rd_data, rd_valid, load_ready, load_done, load_count
    );

endinterface

// File: rtl/tc_program_mem_loader.sv
// Load-stream handshake: write pointer, word count, done pulse, and write strobe.
// Running checksum is built only with TC_PROGRAM_MEM_CHECKSUM_EN.
module tc_program_loader
    import tc_program_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_in_load,
    input  logic              i_valid,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_last,
    output logic              o_ready,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [WORD_W-1:0] o_wdata,
    output logic              o_session_end,
    output logic              o_done,
`ifdef TC_PROGRAM_MEM_CHECKSUM_EN
    output logic [WORD_W-1:0] o_csum,
`endif
    output logic [ADDR_W:0]   o_count
);
    localparam logic [ADDR_W:0] LastCount = (ADDR_W+1)'(DEPTH - 1);

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_done;
    logic              w_accept;

    // A restart (i_start) wins over a word offered in the same cycle.
    assign w_accept      = i_in_load && !i_start && i_valid;
    assign o_ready       = i_in_load;
    assign o_we          = w_accept;
    assign o_waddr       = r_ptr;
    assign o_wdata       = i_data;
    assign o_session_end = w_accept && (i_last || (r_count == LastCount));
    assign o_done        = r_done;
    assign o_count       = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= o_session_end;
            if (i_start) begin
                r_ptr   <= '0;
                r_count <= '0;
            end else if (w_accept) begin
                r_ptr   <= r_ptr + ADDR_W'(1);
                r_count <= r_count + (ADDR_W+1)'(1);
            end
        end
    end

`ifdef TC_PROGRAM_MEM_CHECKSUM_EN
    logic [WORD_W-1:0] r_csum;

    assign o_csum = r_csum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_csum <= '0;
        end else if (i_start) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= r_csum + i_data;
        end
    end
`endif

endmodule

// File: rtl/tc_program_mem.sv
// Program memory with streamed load sessions and multi-lane wrapping reads.
// Define TC_PROGRAM_MEM_CHECKSUM_EN to add the load_csum output.
module tc_program_mem
    import tc_program_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int LANES  = DEF_LANES
) (
    input  logic           clk,
    input  logic           rst,
    tc_program_mem_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [WORD_W-1:0]       r_mem [DEPTH];
    logic [LANES*WORD_W-1:0] r_rd_data;
    logic                    r_rd_valid;
    logic                    w_we;
    logic [ADDR_W-1:0]       w_waddr;
    logic [WORD_W-1:0]       w_wdata;
    logic                    w_session_end;
    logic                    w_rd_fire;
    logic [ADDR_W-1:0]       w_lane_addr [LANES];

    tc_program_loader #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_loader (
        .clk           (clk),
        .rst           (rst),
        .i_start       (bus.load_start),
        .i_in_load     (r_state == LOAD),
        .i_valid       (bus.load_valid),
        .i_data        (bus.load_data),
        .i_last        (bus.load_last),
        .o_ready       (bus.load_ready),
        .o_we          (w_we),
        .o_waddr       (w_waddr),
        .o_wdata       (w_wdata),
        .o_session_end (w_session_end),
        .o_done        (bus.load_done),
`ifdef TC_PROGRAM_MEM_CHECKSUM_EN
        .o_csum        (bus.load_csum),
`endif
        .o_count       (bus.load_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (bus.load_start) w_next_state = LOAD;
            LOAD: begin
                if (bus.load_start)     w_next_state = LOAD;
                else if (w_session_end) w_next_state = RUN;
            end
            RUN:     if (bus.load_start) w_next_state = LOAD;
            default: w_next_state = IDLE;
        endcase
    end

    // Memory has no reset so its contents survive rst and partial sessions.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_lane_addr[k] = bus.addr + ADDR_W'(k);
    end

    assign w_rd_fire = bus.rd_en && (r_state == RUN) && !bus.load_start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                for (int k = 0; k < LANES; k++) begin
                    r_rd_data[k*WORD_W +: WORD_W] <= r_mem[w_lane_addr[k]];
                end
            end
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;

endmodule

// File: tb/tb_tc_program_mem.sv
// Directed bench for tc_program_mem with default parameters (8-bit words, 256 deep, 4 lanes).
// The checksum scenario runs only when TC_PROGRAM_MEM_CHECKSUM_EN is defined.
module tb_tc_program_mem;
    import tc_program_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [7:0] expMem [256];

    tc_program_mem_if #(.WORD_W(8), .DEPTH(256), .LANES(4)) bus ();

    tc_program_mem #(.WORD_W(8), .DEPTH(256), .LANES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] expLanes(input logic [7:0] base);
        logic [31:0] v;
        logic [7:0]  idx;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            idx = base + 8'(k);
            v[k*8 +: 8] = expMem[idx];
        end
        return v;
    endfunction

    task automatic startSession();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic sendWord(input logic [7:0] data, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = data;
        bus.load_last  = last;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic doRead(input logic [7:0] a);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rd_data: got %h expected 00000000", bus.rd_data); end
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_ready: got %b expected 0", bus.load_ready); end
        checks++; if (bus.load_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_done: got %b expected 0", bus.load_done); end
        checks++; if (bus.load_count !== 9'd0) begin errors++; $display("[TB] FAIL reset_load_count: got %0d expected 0", bus.load_count); end
        tick();
        rst = 1'b1;
        bus.addr  = 8'd0;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_rd_ignored: got %b expected 0", bus.rd_valid); end
            checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_load_ready: got %b expected 0", bus.load_ready); end
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic test_load_basic();
        startSession();
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready: got %b expected 1", bus.load_ready); end
        for (int i = 0; i < 4; i++) begin
            sendWord(8'h10 + 8'(i), i == 3);
            expMem[i] = 8'h10 + 8'(i);
        end
        checks++; if (bus.load_done !== 1'b1) begin errors++; $display("[TB] FAIL basic_done: got %b expected 1", bus.load_done); end
        checks++; if (bus.load_count !== 9'd4) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 4", bus.load_count); end
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_ready_drop: got %b expected 0", bus.load_ready); end
        tick();
        checks++; if (bus.load_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", bus.load_done); end
        doRead(8'd0);
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_rd_valid: got %b expected 1", bus.rd_valid); end
        checks++; if (bus.rd_data !== 32'h13121110) begin errors++; $display("[TB] FAIL basic_rd_data: got %h expected 13121110", bus.rd_data); end
        tick();
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_rd_valid_drop: got %b expected 0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 32'h13121110) begin errors++; $display("[TB] FAIL basic_rd_hold: got %h expected 13121110", bus.rd_data); end
    endtask

    task automatic test_random_gaps();
        int sent;
        int handshakes;
        int cycles;
        sent = 0;
        handshakes = 0;
        cycles = 0;
        startSession();
        while (sent < 16 && cycles < 400) begin
            cycles++;
            if ($urandom_range(0, 1) == 1) begin
                bus.load_valid = 1'b1;
                bus.load_data  = 8'h40 + 8'(sent);
                bus.load_last  = (sent == 15);
                if (bus.load_valid && bus.load_ready) handshakes++;
                expMem[sent] = 8'h40 + 8'(sent);
                sent++;
            end else begin
                bus.load_valid = 1'b0;
                bus.load_last  = 1'b0;
            end
            tick();
            bus.load_valid = 1'b0;
            bus.load_last  = 1'b0;
            if (sent < 16) begin
                checks++; if (bus.load_count !== 9'(sent)) begin errors++; $display("[TB] FAIL gaps_count_step: got %0d expected %0d", bus.load_count, sent); end
            end
        end
        checks++; if (sent != 16) begin errors++; $display("[TB] FAIL gaps_budget: got %0d words sent expected 16", sent); end
        checks++; if (bus.load_done !== 1'b1) begin errors++; $display("[TB] FAIL gaps_done: got %b expected 1", bus.load_done); end
        checks++; if (bus.load_count !== 9'd16) begin errors++; $display("[TB] FAIL gaps_count: got %0d expected 16", bus.load_count); end
        checks++; if (handshakes != 16) begin errors++; $display("[TB] FAIL gaps_handshakes: got %0d expected 16", handshakes); end
        for (int a = 0; a < 16; a += 4) begin
            doRead(8'(a));
            checks++; if (bus.rd_data !== expLanes(8'(a))) begin errors++; $display("[TB] FAIL gaps_read@%0d: got %h expected %h", a, bus.rd_data, expLanes(8'(a))); end
        end
    endtask

    task automatic test_restart();
        bus.rd_en      = 1'b1;
        bus.addr       = 8'd0;
        bus.load_start = 1'b1;
        tick();
        bus.rd_en      = 1'b0;
        bus.load_start = 1'b0;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL restart_rd_ignored: got %b expected 0", bus.rd_valid); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("[TB] FAIL restart_ready: got %b expected 1", bus.load_ready); end
        checks++; if (bus.load_count !== 9'd0) begin errors++; $display("[TB] FAIL restart_count_clear: got %0d expected 0", bus.load_count); end
        sendWord(8'h50, 1'b0);
        sendWord(8'h51, 1'b0);
        expMem[0] = 8'h50;
        expMem[1] = 8'h51;
        bus.load_start = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h99;
        tick();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        checks++; if (bus.load_count !== 9'd0) begin errors++; $display("[TB] FAIL restart_count: got %0d expected 0", bus.load_count); end
        sendWord(8'h60, 1'b1);
        expMem[0] = 8'h60;
        checks++; if (bus.load_count !== 9'd1) begin errors++; $display("[TB] FAIL restart_final_count: got %0d expected 1", bus.load_count); end
        tick();
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hEE;
        bus.load_last  = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        checks++; if (bus.load_count !== 9'd1) begin errors++; $display("[TB] FAIL run_valid_ignored: got %0d expected 1", bus.load_count); end
        doRead(8'd0);
        checks++; if (bus.rd_data !== 32'h43425160) begin errors++; $display("[TB] FAIL restart_read: got %h expected 43425160", bus.rd_data); end
    endtask

    task automatic test_reset_midload();
        startSession();
        sendWord(8'hC0, 1'b0);
        sendWord(8'hC1, 1'b0);
        expMem[0] = 8'hC0;
        expMem[1] = 8'hC1;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hC2;
        rst = 1'b0;
        #1;
        bus.load_valid = 1'b0;
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ready: got %b expected 0", bus.load_ready); end
        checks++; if (bus.load_count !== 9'd0) begin errors++; $display("[TB] FAIL midrst_count: got %0d expected 0", bus.load_count); end
        checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("[TB] FAIL midrst_rd_data: got %h expected 00000000", bus.rd_data); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.load_done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_done: got %b expected 0", bus.load_done); end
        end
        rst = 1'b1;
        doRead(8'd0);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_idle: got %b expected 0", bus.rd_valid); end
        startSession();
        sendWord(8'hC0, 1'b1);
        tick();
        doRead(8'd0);
        checks++; if (bus.rd_data !== expLanes(8'd0)) begin errors++; $display("[TB] FAIL midrst_read0: got %h expected %h", bus.rd_data, expLanes(8'd0)); end
        doRead(8'd4);
        checks++; if (bus.rd_data !== expLanes(8'd4)) begin errors++; $display("[TB] FAIL midrst_read4: got %h expected %h", bus.rd_data, expLanes(8'd4)); end
    endtask

    task automatic test_full_wrap();
        startSession();
        for (int i = 0; i < 256; i++) begin
            sendWord(8'(i), 1'b0);
            expMem[i] = 8'(i);
            if (i < 255) begin
                if (bus.load_done !== 1'b0) begin
                    checks++; errors++;
                    $display("[TB] FAIL full_early_done at word %0d: got %b expected 0", i, bus.load_done);
                end
            end
        end
        checks++; if (bus.load_done !== 1'b1) begin errors++; $display("[TB] FAIL full_done: got %b expected 1", bus.load_done); end
        checks++; if (bus.load_count !== 9'd256) begin errors++; $display("[TB] FAIL full_count: got %0d expected 256", bus.load_count); end
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_drop: got %b expected 0", bus.load_ready); end
        doRead(8'd254);
        checks++; if (bus.rd_data !== 32'h0100FFFE) begin errors++; $display("[TB] FAIL full_wrap_read: got %h expected 0100fffe", bus.rd_data); end
        doRead(8'd252);
        checks++; if (bus.rd_data !== 32'hFFFEFDFC) begin errors++; $display("[TB] FAIL full_top_read: got %h expected fffefdfc", bus.rd_data); end
    endtask

`ifdef TC_PROGRAM_MEM_CHECKSUM_EN
    task automatic test_checksum();
        startSession();
        checks++; if (bus.load_csum !== 8'h00) begin errors++; $display("[TB] FAIL csum_clear: got %h expected 00", bus.load_csum); end
        sendWord(8'hFF, 1'b0);
        sendWord(8'h02, 1'b1);
        checks++; if (bus.load_csum !== 8'h01) begin errors++; $display("[TB] FAIL csum_value: got %h expected 01", bus.load_csum); end
        tick();
        tick();
        checks++; if (bus.load_csum !== 8'h01) begin errors++; $display("[TB] FAIL csum_hold: got %h expected 01", bus.load_csum); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        bus.addr       = '0;
        bus.rd_en      = 1'b0;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        test_reset();
        test_load_basic();
        test_random_gaps();
        test_restart();
        test_reset_midload();
        test_full_wrap();
`ifdef TC_PROGRAM_MEM_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
